// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU datapath blocks: weight width, weight type and
// the occupancy-counter width helper.
package tpu_pkg;

    localparam int WEIGHT_W = 8;

    typedef logic [WEIGHT_W-1:0] weight_t;

    // A queue of `depth` entries needs to represent 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/weight_col_fifo.sv
// One column of the weight staging buffer: circular queue with occupancy count,
// full/empty status and a head value gated by the pop accept.
module weight_col_fifo
    import tpu_pkg::*;
#(
    parameter int DATA_W = WEIGHT_W,
    parameter int DEPTH  = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = count_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              accept,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic              push_drop,
    output logic              pop_miss
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push_ok;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign accept    = pop && !clear && !empty;
    // A full column still takes a push when the same cycle's pop frees a slot.
    assign push_ok   = push && !clear && (!full || accept);
    assign push_drop = push && !clear && full && !accept;
    assign pop_miss  = pop && !clear && empty;
    assign head      = accept ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (accept) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !accept) begin
                count <= count + CW'(1);
            end else if (accept && !push_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/weight_fifo_array.sv
// Weight staging buffer for the systolic array: NUM_COLS column queues on a shared
// write bus, a common pop strobe, and a diagonal output skew of c cycles on column c.
module weight_fifo_array
    import tpu_pkg::*;
#(
    parameter int DATA_W   = WEIGHT_W,
    parameter int NUM_COLS = 4,
    parameter int DEPTH    = 4,
    localparam int CW      = count_w(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic [NUM_COLS-1:0]        push_col,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       pop,
    output logic [NUM_COLS*DATA_W-1:0] col_out,
    output logic [NUM_COLS-1:0]        col_valid,
    output logic [NUM_COLS-1:0]        col_full,
    output logic [NUM_COLS-1:0]        col_empty,
    output logic [NUM_COLS*CW-1:0]     col_count,
    output logic                       all_ready,
    output logic                       overflow,
    output logic                       underflow
);

    // Handshake: pop is a strobe with no back-pressure. all_ready tells the producer
    // that every column will accept it; otherwise each column accepts independently
    // and col_valid[c] qualifies col_out[c] in the cycle the weight reaches the array.
    logic [NUM_COLS-1:0] accept;
    logic [NUM_COLS-1:0] push_drop;
    logic [NUM_COLS-1:0] pop_miss;
    logic [DATA_W-1:0]   head [NUM_COLS];

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        weight_col_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_col (
            .clk       (clk),
            .reset_n   (reset_n),
            .clear     (clear),
            .push      (push_col[c]),
            .data_in   (data_in),
            .pop       (pop),
            .head      (head[c]),
            .accept    (accept[c]),
            .full      (col_full[c]),
            .empty     (col_empty[c]),
            .count     (col_count[c*CW +: CW]),
            .push_drop (push_drop[c]),
            .pop_miss  (pop_miss[c])
        );

        if (c == 0) begin : g_direct
            assign col_out[0 +: DATA_W] = head[0];
            assign col_valid[0]         = accept[0];
        end else begin : g_skew
            // Stages shift every cycle so bubbles travel the diagonal as 0/invalid.
            logic [DATA_W-1:0] skew_data [c];
            logic [c-1:0]      skew_valid;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < c; i++) begin
                        skew_data[i] <= '0;
                    end
                    skew_valid <= '0;
                end else if (clear) begin
                    for (int i = 0; i < c; i++) begin
                        skew_data[i] <= '0;
                    end
                    skew_valid <= '0;
                end else begin
                    skew_data[0]  <= head[c];
                    skew_valid[0] <= accept[c];
                    for (int i = 1; i < c; i++) begin
                        skew_data[i]  <= skew_data[i-1];
                        skew_valid[i] <= skew_valid[i-1];
                    end
                end
            end

            assign col_out[c*DATA_W +: DATA_W] = skew_data[c-1];
            assign col_valid[c]                = skew_valid[c-1];
        end
    end

    assign all_ready = &(~col_empty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (|push_drop) begin
                overflow <= 1'b1;
            end
            if (|pop_miss) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/weight_fifo_array.md
# weight_fifo_array

Parametrised weight staging buffer feeding the systolic MMU: `NUM_COLS` independent circular queues share one narrow write bus, pop together on a single strobe, and present their outputs with a per-column diagonal skew. Column `c` reaches the array `c` cycles after column 0. The block generalises the two-column weight FIFO to any width, depth and column count. It adds full/empty/occupancy status, sticky overflow/underflow errors, per-column valid qualifiers and a synchronous flush.

## Interface
- `DATA_W`, 8: weight width in bits.
- `NUM_COLS`, 4: number of columns (≥1).
- `DEPTH`, 4: entries per column queue (power of two, ≥2).
- `clk` input 1: single clock; all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous flush of all queues, skew stages and error flags.
- `push_col` input NUM_COLS: per-column write enables; several may be set at once, each set column stores `data_in`.
- `data_in` input DATA_W: shared write bus.
- `pop` input 1: pop one entry from every column simultaneously.
- `col_out` output NUM_COLS×DATA_W: skewed column outputs.
- `col_valid` output NUM_COLS: `col_out[c]` carries a real popped weight.
- `col_full` output NUM_COLS: queue c holds DEPTH entries.
- `col_empty` output NUM_COLS: queue c holds 0 entries.
- `col_count` output NUM_COLS×$clog2(DEPTH+1): occupancy per column.
- `all_ready` output 1: every column non-empty; a pop is fully accepted.
- `overflow` output 1: sticky, push attempted into a full column.
- `underflow` output 1: sticky, pop attempted while a column was empty.

## Operation
- Each column has `wr_ptr`, `rd_ptr` ($clog2(DEPTH) bits, wrap modulo DEPTH) and a `count`. Full and empty come from `count`, never from pointer compare.
- Push to column c: if `!col_full[c]`, write `data_in` at `wr_ptr`, increment. If full, the push is dropped, the pointer is held and `overflow` is set.
- Pop: each non-empty column advances its `rd_ptr` and emits its head value. Each empty column holds its pointer, emits 0 with valid=0, and `underflow` is set. Columns are handled independently, so a partial pop is possible.
- Simultaneous push and pop on one column:
  - Full: both accepted, count unchanged, no overflow.
  - Empty: the push is accepted and the pop underflows. There is no bypass; the new entry becomes visible next cycle.
- Skew path: column 0 is combinational. `col_out[0]` is the head if pop is accepted on col 0, else 0, and `col_valid[0]` is the accept. Column c≥1 passes the same gated head/accept pair through a c-stage shift register that advances every cycle regardless of `pop`. Bubbles therefore propagate as value 0 with valid=0.
- `clear` (when reset_n high): zero pointers, counts, skew stages and both error flags. Pushes and pops in the same cycle are ignored. Storage contents need not be cleared.
- Storage arrays carry no reset; they are gated by valid, so there is no X leakage on `col_out`.

## Timing
- Reset (async assert, sync-release assumed upstream) leaves:
  - `col_out` = 0, `col_valid` = 0;
  - `col_empty` = all 1, `col_full` = 0, `col_count` = 0;
  - `all_ready` = 0, `overflow` = 0, `underflow` = 0.
- Push at edge N: `col_count`/flags update after N; the entry is poppable from cycle N+1.
- Pop in cycle N: `col_out[0]` is valid in cycle N, combinational from `pop`. `col_out[c]` is valid in cycle N+c.
- Error flags set at the edge after the offending cycle and hold until reset or `clear`.
- Reset asserted mid-burst: in-flight skew data is discarded immediately; no partial weights emerge after release.
- A back-to-back pop every cycle sustains a full-rate diagonal wavefront.

## Structure
- Shared package `tpu_pkg`: `WEIGHT_W` default, a `weight_t` typedef, and a helper function for the count width.
- Sub-module `weight_col_fifo`: one column containing queue, pointers, count, full/empty, gated head and accept. Instantiated NUM_COLS times by generate.
- Top level holds: the skew shift chains (generate, depth c per column), the error-flag flops, the `all_ready` AND-reduction and the push fan-out.

## Test plan
- **Reset:** reset_n=0 mid-operation → all outputs at reset values immediately; after release, col_empty=4'b1111.
- **Fill and wavefront:** NUM_COLS=4, DEPTH=4. Push 0x10..0x13 into col0, 0x20..0x23 into col1, and likewise for col2/col3. Then pop for 4 cycles from cycle T. Required response:
  - col_out[0]=0x10..0x13 in T..T+3;
  - col_out[3]=0x40..0x43 in T+3..T+6;
  - valid aligned with each;
  - counts return to 0.
- **Overflow:** push 5 words to col2 → count=4, col_full[2]=1, 5th word dropped, overflow=1. Pop then returns the first 4 words in order.
- **Underflow / partial pop:** col1 empty, others hold 1 entry, pop → col_valid[1] stays 0 through its skew slot with col_out[1]=0, underflow=1, other columns emit their data.
- **Simultaneous push+pop:**
  - Full column with push+pop → count stays 4, no overflow, FIFO order preserved across pointer wrap.
  - Empty column with push+pop → count=1, underflow=1.
- **Clear:** clear=1 during a wavefront → the next cycle has all valids 0, counts 0, error flags 0; pushes in the clear cycle are ignored.
